// File: rtl/debounce_edge_det.sv
// debounce_edge_det: two-flop synchroniser, stability-counter debounce FSM,
// single-cycle rise/fall pulses and a wrapping rising-edge counter.
module debounce_edge_det #(
   parameter int STABLE_CNT = 4,
   parameter int CNT_W      = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       d,
   input  logic       clr_cnt,
   output logic       q,
   output logic       rise,
   output logic       fall,
   output logic [7:0] edge_cnt
);
   typedef enum logic [1:0] {LOW, CHK_HI, HIGH, CHK_LO} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, s_q;
   logic             lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;
   logic [7:0]       ecnt_q, ecnt_d;
   logic             done;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         state_q <= LOW;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         ecnt_q  <= '0;
      end else begin
         sync1_q <= d;
         s_q     <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         ecnt_q  <= ecnt_d;
      end

   // Any opposite sample during a check drops back to the stable state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      done    = cnt_q == LAST;
      case (state_q)
         LOW:
            if (s_q) begin
               state_d = CHK_HI;
               cnt_d   = '0;
            end
         CHK_HI:
            if (!s_q) begin
               state_d = LOW;
               cnt_d   = '0;
            end else if (done) begin
               state_d = HIGH;
               cnt_d   = '0;
               lvl_d   = 1'b1;
               rise_d  = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
         HIGH:
            if (!s_q) begin
               state_d = CHK_LO;
               cnt_d   = '0;
            end
         CHK_LO:
            if (s_q) begin
               state_d = HIGH;
               cnt_d   = '0;
            end else if (done) begin
               state_d = LOW;
               cnt_d   = '0;
               lvl_d   = 1'b0;
               fall_d  = 1'b1;
            end else cnt_d = cnt_q + CNT_W'(1);
      endcase
      ecnt_d = clr_cnt ? 8'd0 : ecnt_q + {7'd0, rise_d};
   end

   assign q        = lvl_q;
   assign rise     = rise_q;
   assign fall     = fall_q;
   assign edge_cnt = ecnt_q;
endmodule

// File: tb/tb_debounce_edge_det.sv
// tb_debounce_edge_det: default and STABLE_CNT=1 instances driven together and
// checked every cycle against a run-length reference model.
module tb_debounce_edge_det;
   logic       clk = 1'b0, rstn = 1'b0, d = 1'b0, clr_cnt = 1'b0;
   logic       q0, r0, f0, q1, r1, f1;
   logic [7:0] c0, c1;
   int         n_chk = 0, n_fail = 0;
   bit         m_sync1[2], m_s[2], m_q[2], m_rise[2], m_fall[2];
   int         m_run[2], m_cnt[2];
   int         pr, pf;

   debounce_edge_det u0 (.clk(clk), .rstn(rstn), .d(d), .clr_cnt(clr_cnt),
                         .q(q0), .rise(r0), .fall(f0), .edge_cnt(c0));
   debounce_edge_det #(.STABLE_CNT(1), .CNT_W(4)) u1 (
      .clk(clk), .rstn(rstn), .d(d), .clr_cnt(clr_cnt),
      .q(q1), .rise(r1), .fall(f1), .edge_cnt(c1));

   always #5 clk = ~clk;

   function automatic int nstab(int i);
      return i == 0 ? 4 : 1;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         m_sync1[i] = 0; m_s[i] = 0; m_q[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
         m_run[i] = 0; m_cnt[i] = 0;
      end
   endtask

   // The level flips once the synchronised input has differed from it for
   // STABLE_CNT+1 consecutive sampled edges.
   task automatic m_edge();
      for (int i = 0; i < 2; i++) begin
         m_rise[i] = 0;
         m_fall[i] = 0;
         m_run[i]  = (m_s[i] != m_q[i]) ? m_run[i] + 1 : 0;
         if (m_run[i] == nstab(i) + 1) begin
            m_q[i]    = m_s[i];
            m_run[i]  = 0;
            m_rise[i] = m_q[i];
            m_fall[i] = !m_q[i];
         end
         m_cnt[i]   = clr_cnt ? 0 : (m_cnt[i] + int'(m_rise[i])) % 256;
         m_s[i]     = m_sync1[i];
         m_sync1[i] = d;
      end
   endtask

   task automatic chk(string tag, int act, int exp);
      n_chk++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic int pk(logic q, logic r, logic f, logic [7:0] c);
      return int'({q, r, f, c});
   endfunction

   task automatic chk_all(string tag);
      chk({tag, "_d0"}, pk(q0, r0, f0, c0), pk(m_q[0], m_rise[0], m_fall[0], 8'(m_cnt[0])));
      chk({tag, "_d1"}, pk(q1, r1, f1, c1), pk(m_q[1], m_rise[1], m_fall[1], 8'(m_cnt[1])));
   endtask

   task automatic step(logic dv, logic cv, string tag);
      d = dv;
      clr_cnt = cv;
      @(posedge clk);
      if (rstn) m_edge(); else m_reset();
      #1;
      chk_all(tag);
   endtask

   initial begin
      m_reset();
      // reset held with d toggling
      for (int i = 0; i < 6; i++) step(1'(i), 1'b0, "reset");
      rstn = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "settle");
      // clean rise: q and rise appear after edge e0+6
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b0, "rise");
         if (i == 5) chk("rise_early", pk(q0, r0, f0, c0), pk(1'b0, 1'b0, 1'b0, 8'd0));
      end
      chk("rise_lat", pk(q0, r0, f0, c0), pk(1'b1, 1'b1, 1'b0, 8'd1));
      step(1'b1, 1'b0, "rise_one");
      chk("rise_once", int'(r0), 0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, "fall");
      chk("fall_lat", pk(q0, r0, f0, c0), pk(1'b0, 1'b0, 1'b1, 8'd1));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "idle");
      // glitch of 3 cycles, then a 1-0-1 bounce
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "glitch");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "glitch_lo");
      chk("glitch_rej", pk(q0, r0, f0, c0), pk(1'b0, 1'b0, 1'b0, 8'd1));
      step(1'b1, 1'b0, "bounce"); step(1'b1, 1'b0, "bounce");
      step(1'b0, 1'b0, "bounce");
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b0, "bounce_hi");
         if (i == 5) chk("bounce_early", int'(q0), 0);
      end
      chk("bounce_lat", pk(q0, r0, f0, c0), pk(1'b1, 1'b1, 1'b0, 8'd2));
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "lo");
      // wrap after 256 rises
      step(1'b0, 1'b1, "clr");
      chk("clr", int'(c0), 0);
      for (int p = 0; p < 256; p++) begin
         for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "wrap");
         for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "wrap");
      end
      chk("wrap", int'(c0), 0);
      // clear coinciding with rise
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, "coin");
      step(1'b1, 1'b1, "coin_clr");
      chk("coin", pk(q0, r0, f0, c0), pk(1'b1, 1'b1, 1'b0, 8'd0));
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "hold");
      // asynchronous reset while q=1
      @(negedge clk);
      rstn = 1'b0;
      #1;
      m_reset();
      chk_all("areset");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "in_reset");
      rstn = 1'b1;
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "post_rst");
      chk("post_rst", pk(q0, r0, f0, c0), pk(1'b1, 1'b1, 1'b0, 8'd1));
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "lo1");
      // STABLE_CNT=1: 2-cycle pulse passes, 1-cycle pulse is rejected
      pr = 0; pf = 0;
      step(1'b1, 1'b0, "p2"); pr += int'(r1); pf += int'(f1);
      step(1'b1, 1'b0, "p2"); pr += int'(r1); pf += int'(f1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, "p2_lo"); pr += int'(r1); pf += int'(f1);
      end
      chk("p2_pulses", pr * 16 + pf, 17);
      pr = 0; pf = 0;
      step(1'b1, 1'b0, "p1"); pr += int'(r1); pf += int'(f1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, "p1_lo"); pr += int'(r1); pf += int'(f1);
      end
      chk("p1_pulses", pr * 16 + pf, 0);
      // random bouncing input
      for (int seg = 0; seg < 400; seg++) begin
         logic lv;
         int   len;
         lv  = 1'($urandom);
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++) step(lv, 1'($urandom_range(0, 19) == 0), "rand");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/debounce_edge_det.md
# debounce_edge_det

Debounce-and-edge-detect stage that sits directly downstream of the asynchronous-reset D flip-flop. It takes a raw, asynchronous, possibly bouncing 1-bit input and synchronises it with two flops. It then filters it through a stability counter and presents a clean level, single-cycle rise/fall pulses and a rising-edge event count to the logic behind it.

## Interface
Parameters:
- STABLE_CNT, default 4: consecutive cycles the synchronised input must hold a new level, after the first sample, before the output changes. Legal range 1 to 2^CNT_W.
- CNT_W, default 4: width of the internal stability counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rstn  input  1  reset, asynchronous and active-low.
- d  input  1  raw asynchronous input; may bounce.
- clr_cnt  input  1  synchronous clear of edge_cnt.
- q  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse on a debounced 0->1 transition.
- fall  output  1  one-cycle pulse on a debounced 1->0 transition.
- edge_cnt  output  8  count of debounced rising edges; wraps modulo 256.

## Operation
- Synchroniser: two flops, sync1 <= d and s <= sync1. Both reset to 0. The FSM samples only s.
- FSM states:
  - LOW: q=0.
  - CHK_HI: candidate high.
  - HIGH: q=1.
  - CHK_LO: candidate low.
- Stability counter cnt (CNT_W bits).
- Transitions, evaluated each rising edge:
  - LOW: if s=1, go to CHK_HI with cnt<=0. Otherwise stay.
  - CHK_HI:
    - If s=0, go to LOW with cnt<=0 (glitch rejected, no pulse).
    - Else if cnt==STABLE_CNT-1, go to HIGH, set q<=1 and rise<=1.
    - Else cnt<=cnt+1.
  - HIGH: if s=0, go to CHK_LO with cnt<=0.
  - CHK_LO: mirror of CHK_HI.
    - If s=1, return to HIGH.
    - On completion, go to LOW with q<=0 and fall<=1.
- q changes only on completion of a check. During CHK_HI q stays 0; during CHK_LO q stays 1.
- rise and fall are registered and high for exactly one cycle. They are never high together.
- edge_cnt:
  - Increments by 1 in the same edge that sets rise.
  - Wraps from 255 to 0.
  - clr_cnt=1 sets it to 0 on the next edge. If clr_cnt and a rise coincide, the clear wins and edge_cnt becomes 0.
- A bounce shorter than the check window never produces a pulse. Any sample of the opposite level restarts the decision from the stable state.

## Timing
- Reset (rstn=0), asynchronous and immediate:
  - sync1=s=0, state=LOW, cnt=0.
  - q=0, rise=0, fall=0, edge_cnt=0.
- Reset mid-operation: all of the above is forced at once, with no fall pulse even if q was 1.
- Reset release with d held high: treated as a fresh 0->1 transition. The block debounces normally and emits rise.
- Latency: d changes before rising edge e0 and then stays stable.
  - s reflects the new level after edge e0+1.
  - The FSM enters the check state at edge e0+2.
  - q, rise or fall update at edge e0+2+STABLE_CNT.
  - With the default STABLE_CNT=4, q changes after edge e0+6.
- Minimum stable width: s must hold the new level for STABLE_CNT+1 consecutive sampled edges.
- STABLE_CNT=1: the check state lasts one cycle, and the output updates at edge e0+3.
- edge_cnt updates in the same cycle that rise is high.

## Test plan
1. Reset: hold rstn=0 with d toggling -> q=0, rise=0, fall=0, edge_cnt=0 throughout.
2. Clean rise: d 0->1 before edge e0, then held -> q=1 and rise=1 for one cycle after edge e0+6; edge_cnt=1. Then d 1->0 -> fall=1 for one cycle after 6 edges, and q=0.
3. Glitch rejection: d high for 3 cycles, then low -> q stays 0, no rise, edge_cnt unchanged. Bounce 1-0-1 inside the window -> q=1 only 6 edges after the last 0->1.
4. Wrap and clear: 256 clean pulses -> edge_cnt=0 after the last rise. clr_cnt asserted in the same cycle as a rise -> edge_cnt=0.
5. Reset mid-operation: q=1, then rstn=0 -> q=0 immediately and no fall pulse. Release with d=1 -> rise after e0+6 and edge_cnt=1.
6. STABLE_CNT=1 build: a 2-cycle d pulse -> rise, then fall. A 1-cycle d pulse -> no pulse.
